rv32i_mem_stage: RTL and testbench
==================================

// Module: rv32i_mem_stage
// PURPOSE
//  Memory stage of the RV32I pipeline; consumes the execute-stage result bundle.
//  Issues load/store requests to data memory over a req/ack handshake and stalls upstream while waiting.
//  Aligns and extends load data, registers the writeback bundle for the WB stage, and forwards MEM results to decode.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max WAIT cycles before a request is aborted with bus_err
//  CNT_W           5   wait-counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1   system clock; all state on posedge
//  reset          in   1   asynchronous, active-high reset
//  alu_in         in   32  EX result; effective address for loads/stores
//  iw_in          in   32  instruction word
//  pc_in          in   32  instruction PC
//  rs2_data_in    in   32  store data
//  src_sel_in     in   2   00 = ALU result, 01 = load data, 1x = ALU result
//  wb_en_in       in   1   writeback enable
//  wb_reg_in      in   5   writeback register
//  dmem_req       out  1   request valid; held until dmem_ack
//  dmem_we        out  1   1 = store, 0 = load
//  dmem_addr      out  32  word address {alu_in[31:2],2'b00}
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables
//  dmem_ack       in   1   memory completes the request this cycle; rdata valid
//  dmem_rdata     in   32  read word
//  stall_out      out  1   upstream stages hold all inputs stable while 1
//  wb_data_out    out  32  registered writeback data
//  wb_reg_out     out  5   registered writeback register
//  wb_en_out      out  1   registered writeback enable
//  iw_out         out  32  registered instruction word
//  pc_out         out  32  registered PC
//  misalign_err   out  1   registered one-cycle pulse: misaligned access dropped
//  bus_err        out  1   registered one-cycle pulse: request timed out
//  df_mem_enable  out  1   forward valid: wb_en_in & (~load | dmem_ack)
//  df_mem_pending out  1   wb_en_in & load & ~dmem_ack; decode stalls on match
//  df_mem_reg     out  5   wb_reg_in
//  df_mem_data    out  32  result that would be written next edge
// BEHAVIOUR
//  Decode
//   - Load = iw_in[6:0]==0000011; store = 0100011; funct3 = iw_in[14:12].
//   - Misaligned: half access with addr[0]==1; word access with addr[1:0]!=0.
//   - Misaligned access: no request, no stall; misalign_err=1 next cycle; wb_en_out=0.
//  FSM
//   - States: IDLE, WAIT.
//   - IDLE, aligned mem op: dmem_req=1 combinationally.
//     - dmem_ack same cycle: complete, stay IDLE.
//     - no ack: go to WAIT, counter=1.
//   - WAIT: dmem_req=1; counter increments each cycle.
//     - ack: complete, go to IDLE.
//     - counter==TIMEOUT_CYCLES without ack: abort, go to IDLE; bus_err=1 next cycle; wb_en_out=0.
//   - Ack and timeout in the same cycle: ack wins.
//   - Request outputs (we/addr/wdata/be) are driven from inputs, which stay stable under stall.
//  Stall and pipeline registers
//   - stall_out = aligned mem op & ~dmem_ack & ~timeout; combinational.
//   - Each edge with stall_out=1 loads a bubble: wb_en_out=0, iw_out=0, pc_out=0, wb_data_out=0, wb_reg_out=0.
//   - Non-mem ops: one-cycle latency pass-through; wb_data_out=alu_in.
//   - Stores complete the handshake and pass wb_en_in through (normally 0).
//  Load data
//   - Lane = addr[1:0].
//   - LB/LBU: byte at lane, sign/zero extended.
//   - LH/LHU: half at addr[1]*16, sign/zero extended.
//   - LW: full word.
//   - Illegal funct3: no request; treated as misaligned.
//  Store data
//   - SB: wdata={4{rs2[7:0]}}, be=0001<<addr[1:0].
//   - SH: wdata={2{rs2[15:0]}}, be=0011<<addr[1:0].
//   - SW: wdata=rs2, be=1111.
//  Reset
//   - Async; all registered outputs 0; state IDLE; counter 0; dmem_req=0 immediately.
//   - Reset during WAIT abandons the request; no error pulse is raised.
// TESTING
//  1. ADD, alu_in=0x00000055, wb_en_in=1, wb_reg_in=5 -> next cycle wb_data_out=0x55, wb_reg_out=5, wb_en_out=1; no dmem_req.
//  2. SW addr 0x100, rs2=0xDEADBEEF, ack in same cycle -> req=1, we=1, be=1111, wdata=0xDEADBEEF, stall_out=0.
//  3. LB addr 0x103, ack after 3 wait cycles, rdata=0x80123456 -> stall_out high 3 cycles; then wb_data_out=0xFFFFFF80.
//  4. LHU addr 0x102, rdata=0x80014321 -> wb_data_out=0x00008001. SB addr 0x101, rs2=0xAB -> be=0010, wdata=0xABABABAB.
//  5. LW addr 0x101 -> no req; misalign_err pulses 1 cycle; wb_en_out=0.
//     LW with no ack -> stall 16 cycles, then bus_err pulse, stall_out drops.
//  6. Assert reset mid-WAIT -> dmem_req, stall_out and all outputs 0 without a clock edge; after release, the next LW issues from IDLE.

Source files
------------

// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: issues data-memory requests over req/ack, stalls upstream while waiting,
// aligns/extends load data and registers the writeback bundle.
module rv32i_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs2_data_in,
  input  logic [1:0]  src_sel_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_en_out,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        df_mem_enable,
  output logic        df_mem_pending,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wb_data_q, wb_data_d, iw_q, iw_d, pc_q, pc_d;
  logic [4:0]       wb_reg_q, wb_reg_d;
  logic             wb_en_q, wb_en_d, misalign_err_q, misalign_err_d, bus_err_q, bus_err_d;

  logic        is_load, is_store, mem_op, bad_access, aligned_op, timeout, abort;
  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data, result;

  assign funct3   = iw_in[14:12];
  assign lane     = alu_in[1:0];
  assign is_load  = (iw_in[6:0] == OpLoad);
  assign is_store = (iw_in[6:0] == OpStore);
  assign mem_op   = is_load | is_store;

  // Illegal funct3 is folded into the misaligned path: no request, error pulse.
  always_comb begin
    bad_access = 1'b1;
    unique case (funct3[1:0])
      2'b00:   bad_access = is_store & funct3[2];
      2'b01:   bad_access = (is_store & funct3[2]) | alu_in[0];
      2'b10:   bad_access = funct3[2] | (|alu_in[1:0]);
      default: bad_access = 1'b1;
    endcase
  end

  assign aligned_op = mem_op & ~bad_access;
  assign timeout    = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign abort      = aligned_op & timeout & ~dmem_ack;

  assign dmem_req  = ~reset & aligned_op;
  assign stall_out = ~reset & aligned_op & ~dmem_ack & ~timeout;
  assign dmem_we   = is_store;
  assign dmem_addr = {alu_in[31:2], 2'b00};

  always_comb begin
    dmem_wdata = rs2_data_in;
    dmem_be    = 4'b1111;
    unique case (funct3[1:0])
      2'b00: begin
        dmem_wdata = {4{rs2_data_in[7:0]}};
        dmem_be    = 4'b0001 << lane;
      end
      2'b01: begin
        dmem_wdata = {2{rs2_data_in[15:0]}};
        dmem_be    = 4'b0011 << lane;
      end
      default: ;
    endcase
  end

  assign byte_sel = dmem_rdata[{lane, 3'b000} +: 8];
  assign half_sel = alu_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    unique case (funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  assign result = (src_sel_in == 2'b01) ? load_data : alu_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (aligned_op && !dmem_ack) begin
          state_d = StWait;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin
        if (dmem_ack || timeout || !aligned_op) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    wb_data_d      = '0;
    wb_reg_d       = '0;
    wb_en_d        = 1'b0;
    iw_d           = '0;
    pc_d           = '0;
    misalign_err_d = 1'b0;
    bus_err_d      = 1'b0;
    if (!stall_out) begin
      wb_data_d      = result;
      wb_reg_d       = wb_reg_in;
      wb_en_d        = wb_en_in & ~(mem_op & bad_access) & ~abort;
      iw_d           = iw_in;
      pc_d           = pc_in;
      misalign_err_d = mem_op & bad_access;
      bus_err_d      = abort;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      wb_data_q      <= '0;
      wb_reg_q       <= '0;
      wb_en_q        <= 1'b0;
      iw_q           <= '0;
      pc_q           <= '0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_data_q      <= wb_data_d;
      wb_reg_q       <= wb_reg_d;
      wb_en_q        <= wb_en_d;
      iw_q           <= iw_d;
      pc_q           <= pc_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign wb_data_out  = wb_data_q;
  assign wb_reg_out   = wb_reg_q;
  assign wb_en_out    = wb_en_q;
  assign iw_out       = iw_q;
  assign pc_out       = pc_q;
  assign misalign_err = misalign_err_q;
  assign bus_err      = bus_err_q;

  assign df_mem_enable  = wb_en_in & (~is_load | dmem_ack);
  assign df_mem_pending = wb_en_in & is_load & ~dmem_ack;
  assign df_mem_reg     = wb_reg_in;
  assign df_mem_data    = result;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Bench for rv32i_mem_stage: vector table, randomized ops against a byte-level model,
// and hand sequences for wait states, timeout and reset.
module tb_rv32i_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_in, iw_in, pc_in, rs2_data_in, dmem_rdata;
  logic [1:0]  src_sel_in;
  logic        wb_en_in, dmem_ack;
  logic [4:0]  wb_reg_in;
  logic        dmem_req, dmem_we, stall_out, wb_en_out, misalign_err, bus_err;
  logic        df_mem_enable, df_mem_pending;
  logic [31:0] dmem_addr, dmem_wdata, wb_data_out, iw_out, pc_out, df_mem_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_reg_out, df_mem_reg;

  int errors = 0;
  int checks = 0;

  rv32i_mem_stage dut (
    .clk(clk), .reset(reset), .alu_in(alu_in), .iw_in(iw_in), .pc_in(pc_in),
    .rs2_data_in(rs2_data_in), .src_sel_in(src_sel_in), .wb_en_in(wb_en_in),
    .wb_reg_in(wb_reg_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .wb_data_out(wb_data_out), .wb_reg_out(wb_reg_out),
    .wb_en_out(wb_en_out), .iw_out(iw_out), .pc_out(pc_out), .misalign_err(misalign_err),
    .bus_err(bus_err), .df_mem_enable(df_mem_enable), .df_mem_pending(df_mem_pending),
    .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iw, alu, rs2, rdata;
    logic        wb_en;
    logic [1:0]  src;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] wdata, wbdata;
    logic        wben, merr, chkd;
  } vec_t;

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_iw(logic [6:0] opc, logic [2:0] f3);
    return {17'b0, f3, 5'b0, opc};
  endfunction

  // Access size in bytes; 0 means the funct3 is not a legal access.
  function automatic int ref_size(logic is_store, logic [2:0] f3);
    if (is_store) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    return (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int unsigned off = a % 4;
    logic [31:0] v;
    if (f3 == 0 || f3 == 4) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 32'd256;
    end else if (f3 == 1 || f3 == 5) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic vec_t build_vec(int k, logic [31:0] a, logic [31:0] rs2, logic [31:0] rd);
    vec_t v;
    logic [2:0] f3s [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    logic st = (k >= 6);
    logic ld = (k >= 1 && k <= 5);
    int   sz = ref_size(st, f3s[k]);
    logic bad = (ld || st) && (sz == 0 || (a % sz) != 0);
    v.iw = mk_iw(k == 0 ? 7'h33 : (st ? 7'h23 : 7'h03), f3s[k]);
    v.alu = a; v.rs2 = rs2; v.rdata = rd;
    v.wb_en = !st;
    v.src   = ld ? 2'b01 : 2'b00;
    v.req   = (ld || st) && !bad;
    v.we    = st;
    v.be    = 4'b0;
    for (int i = 0; i < sz; i++) v.be[(a % 4) + i] = 1'b1;
    v.wdata = (sz == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
              (sz == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
    v.wbdata = ld ? ref_load(f3s[k], a, rd) : a;
    v.wben   = !st && !bad;
    v.merr   = bad;
    v.chkd   = !bad;
    return v;
  endfunction

  function automatic vec_t mkv(logic [31:0] iw, a, rs2, rd, logic wen, logic [1:0] src,
                               logic req, we, logic [3:0] be, logic [31:0] wd, wbd,
                               logic wben, merr, chkd);
    vec_t v;
    v.iw = iw; v.alu = a; v.rs2 = rs2; v.rdata = rd; v.wb_en = wen; v.src = src;
    v.req = req; v.we = we; v.be = be; v.wdata = wd; v.wbdata = wbd;
    v.wben = wben; v.merr = merr; v.chkd = chkd;
    return v;
  endfunction

  task automatic drive(logic [31:0] iw, a, rs2, rd, logic ack, logic wen,
                       logic [1:0] src, logic [4:0] wreg);
    iw_in = iw; alu_in = a; rs2_data_in = rs2; dmem_rdata = rd; dmem_ack = ack;
    wb_en_in = wen; src_sel_in = src; wb_reg_in = wreg; pc_in = a ^ 32'h4000_0000;
  endtask

  // Called at posedge+1; returns at posedge+1 after the vector's edge.
  task automatic run_vec(string tag, vec_t v);
    drive(v.iw, v.alu, v.rs2, v.rdata, 1'b1, v.wb_en, v.src, 5'd9);
    #3;
    chk1({tag, " req"}, dmem_req, v.req);
    chk1({tag, " stall"}, stall_out, 1'b0);
    chk1({tag, " df_en"}, df_mem_enable, v.wb_en);
    if (v.req) begin
      chk1({tag, " we"}, dmem_we, v.we);
      chk32({tag, " addr"}, dmem_addr, v.alu & 32'hFFFF_FFFC);
      if (v.we) begin
        chk32({tag, " be"}, {28'b0, dmem_be}, {28'b0, v.be});
        chk32({tag, " wdata"}, dmem_wdata, v.wdata);
      end
    end
    @(posedge clk); #1;
    chk1({tag, " wb_en_out"}, wb_en_out, v.wben);
    chk1({tag, " misalign_err"}, misalign_err, v.merr);
    chk1({tag, " bus_err"}, bus_err, 1'b0);
    if (v.chkd) begin
      chk32({tag, " wb_data_out"}, wb_data_out, v.wbdata);
      chk32({tag, " iw_out"}, iw_out, v.iw);
      chk32({tag, " pc_out"}, pc_out, v.alu ^ 32'h4000_0000);
      chk32({tag, " wb_reg_out"}, {27'b0, wb_reg_out}, 32'd9);
    end
  endtask

  // Inputs hold an aligned LW with no ack; starts and ends at posedge+1.
  task automatic timeout_seq(string tag);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (!stall_out) break;
      n++;
      @(posedge clk); #1;
    end
    chk32({tag, " stall cycles"}, 32'(n), 32'd16);
    if (n < 40) begin
      @(posedge clk); #1;
    end
    chk1({tag, " bus_err pulse"}, bus_err, 1'b1);
    chk1({tag, " wb_en_out"}, wb_en_out, 1'b0);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 5'd0);
    @(posedge clk); #1;
    chk1({tag, " bus_err drop"}, bus_err, 1'b0);
  endtask

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mkv(mk_iw(7'h33, 3'd0), 32'h55, 0, 0, 1, 2'b00, 0, 0, 0, 0, 32'h55, 1, 0, 1);
    tbl[1]  = mkv(mk_iw(7'h23, 3'd2), 32'h100, 32'hDEADBEEF, 0, 0, 2'b00,
                  1, 1, 4'b1111, 32'hDEADBEEF, 32'h100, 0, 0, 1);
    tbl[2]  = mkv(mk_iw(7'h03, 3'd5), 32'h102, 0, 32'h80014321, 1, 2'b01,
                  1, 0, 0, 0, 32'h0000_8001, 1, 0, 1);
    tbl[3]  = mkv(mk_iw(7'h23, 3'd0), 32'h101, 32'hAB, 0, 0, 2'b00,
                  1, 1, 4'b0010, 32'hABABABAB, 32'h101, 0, 0, 1);
    tbl[4]  = mkv(mk_iw(7'h03, 3'd2), 32'h101, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mkv(mk_iw(7'h03, 3'd0), 32'h103, 0, 32'h80123456, 1, 2'b01,
                  1, 0, 0, 0, 32'hFFFF_FF80, 1, 0, 1);
    tbl[6]  = mkv(mk_iw(7'h03, 3'd4), 32'h101, 0, 32'h0000F100, 1, 2'b01,
                  1, 0, 0, 0, 32'h0000_00F1, 1, 0, 1);
    tbl[7]  = mkv(mk_iw(7'h03, 3'd1), 32'h100, 0, 32'h12348765, 1, 2'b01,
                  1, 0, 0, 0, 32'hFFFF_8765, 1, 0, 1);
    tbl[8]  = mkv(mk_iw(7'h23, 3'd1), 32'h102, 32'h1234CAFE, 0, 0, 2'b00,
                  1, 1, 4'b1100, 32'hCAFECAFE, 32'h102, 0, 0, 1);
    tbl[9]  = mkv(mk_iw(7'h03, 3'd1), 32'h103, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mkv(mk_iw(7'h03, 3'd3), 32'h100, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[11] = mkv(mk_iw(7'h03, 3'd2), 32'h104, 0, 32'hCAFEBABE, 1, 2'b01,
                  1, 0, 0, 0, 32'hCAFEBABE, 1, 0, 1);

    reset = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 5'd0);
    #2;
    chk1("reset wb_en_out", wb_en_out, 1'b0);
    chk32("reset wb_data_out", wb_data_out, 32'h0);
    chk1("reset dmem_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 60; i++)
      run_vec($sformatf("rnd%0d", i),
              build_vec(int'($urandom_range(0, 8)), $urandom, $urandom, $urandom));

    // LB with three wait states before ack
    drive(mk_iw(7'h03, 3'd0), 32'h103, 0, 32'h80123456, 1'b0, 1'b1, 2'b01, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #3;
      chk1("lb_wait stall", stall_out, 1'b1);
      chk1("lb_wait req", dmem_req, 1'b1);
      chk1("lb_wait df_pending", df_mem_pending, 1'b1);
      @(posedge clk); #1;
      chk1("lb_wait bubble", wb_en_out, 1'b0);
    end
    dmem_ack = 1'b1;
    #3;
    chk1("lb_ack stall", stall_out, 1'b0);
    chk1("lb_ack df_en", df_mem_enable, 1'b1);
    chk32("lb_ack df_data", df_mem_data, 32'hFFFF_FF80);
    @(posedge clk); #1;
    chk32("lb_ack wb_data_out", wb_data_out, 32'hFFFF_FF80);
    chk1("lb_ack wb_en_out", wb_en_out, 1'b1);
    chk32("lb_ack wb_reg_out", {27'b0, wb_reg_out}, 32'd7);

    // LW never acked
    drive(mk_iw(7'h03, 3'd2), 32'h200, 0, 0, 1'b0, 1'b1, 2'b01, 5'd3);
    timeout_seq("timeout");

    // Async reset clears registered outputs with no clock edge
    drive(mk_iw(7'h33, 3'd0), 32'h55, 0, 0, 1'b0, 1'b1, 2'b00, 5'd5);
    @(posedge clk); #1;
    chk32("add wb_data_out", wb_data_out, 32'h55);
    #2 reset = 1'b1;
    #1;
    chk32("async_rst wb_data_out", wb_data_out, 32'h0);
    chk1("async_rst wb_en_out", wb_en_out, 1'b0);
    chk32("async_rst iw_out", iw_out, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the middle of WAIT abandons the request
    drive(mk_iw(7'h03, 3'd2), 32'h300, 0, 0, 1'b0, 1'b1, 2'b01, 5'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk1("wait_rst req", dmem_req, 1'b0);
    chk1("wait_rst stall", stall_out, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk1("wait_rst no bus_err", bus_err, 1'b0);
    timeout_seq("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
